// File: rtl/mtm_alu_pkg.sv
// Shared constants, frame FSM encoding and CRC-4 helper for the mtm ALU serial receiver.
package mtm_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } frame_state_t;

    localparam logic       PKT_DATA     = 1'b0;
    localparam logic       PKT_CMD      = 1'b1;
    localparam logic [3:0] DATA_BYTES   = 4'd8;
    localparam logic [3:0] BYTE_CNT_OVF = 4'd9;
    localparam logic [3:0] CRC4_POLY    = 4'b0011;   // x^4 + x + 1, implicit x^4

    // MSB-first CRC-4 over {B, A, 1'b1, OP}, init 0
    function automatic logic [3:0] crc4_68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_rx_frame.sv
// Bit-level receiver for 11-bit packets: start(0), type, 8 payload bits MSB first, stop(1).
//   state   | meaning
//   IDLE    | line idle, waiting for a start bit (sin==0)
//   TYPE    | sampling the packet type bit
//   DATA    | shifting in 8 payload bits
//   STOP    | sampling the stop bit; pkt_done is high this cycle
module mtm_alu_rx_frame
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic       pkt_done,
    output logic       pkt_type,
    output logic [7:0] pkt_byte,
    output logic       pkt_frame_err
);

    frame_state_t state, state_nxt;
    logic [2:0]   bit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!sin) state_nxt = ST_TYPE;
            ST_TYPE: state_nxt = ST_DATA;
            ST_DATA: if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            ST_STOP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Done is combinational so the top acts on the same edge that samples the stop bit
    always_comb begin
        pkt_done      = 1'b0;
        pkt_frame_err = 1'b0;
        if (state == ST_STOP) begin
            pkt_done      = 1'b1;
            pkt_frame_err = ~sin;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            pkt_type <= PKT_DATA;
            pkt_byte <= 8'h00;
        end else begin
            case (state)
                ST_TYPE: begin
                    pkt_type <= sin;
                    bit_cnt  <= 3'd0;
                end
                ST_DATA: begin
                    pkt_byte <= {pkt_byte[6:0], sin};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Transaction layer of the mtm ALU input: collects 8 data bytes and a command into A/B/OP/CRC.
// Optional CRC verification is enabled by defining MTM_ALU_DESER_CRC_CHECK_EN.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OP,
    output logic [3:0]  CRC,
    output logic        valid,
    output logic        err_data,
    output logic        err_crc
);

    logic       pkt_done;
    logic       pkt_type;
    logic [7:0] pkt_byte;
    logic       pkt_frame_err;
    logic [3:0] byte_cnt;
    logic [63:0] data_buf;   // {B, A}, slot 0 at the top

    mtm_alu_rx_frame u_frame (
        .clk           (clk),
        .rst_n         (rst_n),
        .sin           (sin),
        .pkt_done      (pkt_done),
        .pkt_type      (pkt_type),
        .pkt_byte      (pkt_byte),
        .pkt_frame_err (pkt_frame_err)
    );

`ifdef MTM_ALU_DESER_CRC_CHECK_EN
    logic crc_ok;
    assign crc_ok = (crc4_68({data_buf, 1'b1, pkt_byte[6:4]}) == pkt_byte[3:0]);
`else
    assign err_crc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A        <= 32'h0;
            B        <= 32'h0;
            OP       <= 3'h0;
            CRC      <= 4'h0;
            valid    <= 1'b0;
            err_data <= 1'b0;
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
            err_crc  <= 1'b0;
`endif
            byte_cnt <= 4'd0;
            data_buf <= 64'h0;
        end else begin
            valid    <= 1'b0;
            err_data <= 1'b0;
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
            err_crc  <= 1'b0;
`endif
            if (pkt_done) begin
                if (pkt_frame_err) begin
                    byte_cnt <= BYTE_CNT_OVF;
                end else if (pkt_type == PKT_DATA) begin
                    if (byte_cnt < DATA_BYTES) begin
                        for (int k = 0; k < 8; k++)
                            if (byte_cnt == 4'(k)) data_buf[63 - 8*k -: 8] <= pkt_byte;
                        byte_cnt <= byte_cnt + 4'd1;
                    end else begin
                        byte_cnt <= BYTE_CNT_OVF;
                    end
                end else begin
                    byte_cnt <= 4'd0;
                    if (byte_cnt == DATA_BYTES) begin
                        B   <= data_buf[63:32];
                        A   <= data_buf[31:0];
                        OP  <= pkt_byte[6:4];
                        CRC <= pkt_byte[3:0];
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
                        if (crc_ok) valid   <= 1'b1;
                        else        err_crc <= 1'b1;
`else
                        valid <= 1'b1;
`endif
                    end else begin
                        err_data <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
